// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Drives the trigger FFT core (xfft_trigger). After reset it sends the core's
// configuration word. It then counts incoming samples, and once every
// HOP_SAMPLES samples it streams one FRAME_LEN-sample window from the circular
// sample RAM into the core's data channel. Before starting the next frame it
// waits for the core's output frame to complete. A start that finds two or
// more hops' worth of samples waiting sets the sticky overrun flag.
//
// Optional feature: when FFT_SEQ_RUNTIME_CFG_EN is defined, the block gains
// cfg_scale/cfg_update and re-sends the config word from IDLE.
//
// Ports:
//   clk, reset_b           system clock, async active-low reset
//   enable                 permits new frame starts
//   sample_ready           one pulse per sample written into the sample RAM
//   wr_addr                RAM write pointer (= address of the oldest sample)
//   ram_rd_addr/_data      RAM read port, data registered (1-cycle latency)
//   cfg_t*                 core config channel {0, scale[5:0], fwd=1}
//   s_t*                   core data channel, tlast on the final beat
//   m_tvalid/tready/tlast  monitored core output handshake
//   frame_busy             high from frame start until the output completes
//   frame_done             one-cycle pulse when the output frame completes
//   overrun, overrun_clr   sticky skipped-hop flag and its clear
//   cfg_scale, cfg_update  (FFT_SEQ_RUNTIME_CFG_EN only) runtime scale update
//
// state  | meaning
// -------+-------------------------------------------------
// CONFIG | config word offered until cfg_tready
// IDLE   | waiting for enable and a full hop of samples
// STREAM | reading RAM and delivering FRAME_LEN beats
// DRAIN  | waiting for the core's output tlast handshake
// DONE   | frame_done pulse; no start evaluated here

module fft_frame_sequencer #(
    parameter int         FRAME_LEN      = 64,
    parameter int         ADDR_W         = 6,
    parameter int         DATA_W         = 10,
    parameter int         HOP_SAMPLES    = 4,
    parameter logic [5:0] SCALE_SCHEDULE = 6'b101011
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              enable,
    input  logic              sample_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              cfg_tvalid,
    output logic [7:0]        cfg_tdata,
    input  logic              cfg_tready,
    output logic              s_tvalid,
    output logic [31:0]       s_tdata,
    output logic              s_tlast,
    input  logic              s_tready,
    input  logic              m_tvalid,
    input  logic              m_tready,
    input  logic              m_tlast,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef FFT_SEQ_RUNTIME_CFG_EN
    ,
    input  logic [5:0]        cfg_scale,
    input  logic              cfg_update
`endif
);

    localparam int                CNT_W   = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  HOP_LVL = CNT_W'(HOP_SAMPLES);
    localparam logic [CNT_W:0]    OVR_LVL = (CNT_W + 1)'(2 * HOP_SAMPLES);
    localparam logic [CNT_W-1:0]  LEN_CNT = CNT_W'(FRAME_LEN);

    typedef enum logic [2:0] {CONFIG, IDLE, STREAM, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    hop_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic [ADDR_W-1:0]   beat_cnt;
    logic                inflight;
    logic [DATA_W-1:0]   skid [2];
    logic                skid_wr_ptr, skid_rd_ptr;
    logic [1:0]          skid_cnt;
    logic [2:0]          occ_after_pop;
    logic                cfg_hs, start, pop, issue, out_done, cfg_pend_idle;
    logic [5:0]          cfg_scale_q;

    assign cfg_hs     = cfg_tvalid && cfg_tready;
    assign pop        = s_tvalid && s_tready;
    assign out_done   = m_tvalid && m_tready && m_tlast;
    assign s_tvalid   = (skid_cnt != 2'd0);
    assign s_tlast    = s_tvalid && (beat_cnt == ADDR_W'(FRAME_LEN - 1));
    assign s_tdata    = {16'b0, {(16 - DATA_W){1'b0}}, skid[skid_rd_ptr]};
    assign cfg_tdata  = {1'b0, cfg_scale_q, 1'b1};
    assign frame_busy = (state == STREAM) || (state == DRAIN);
    assign frame_done = (state == DONE);

`ifdef FFT_SEQ_RUNTIME_CFG_EN
    logic       cfg_pend;
    logic [5:0] pend_scale;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cfg_pend    <= 1'b0;
            pend_scale  <= SCALE_SCHEDULE;
            cfg_scale_q <= SCALE_SCHEDULE;
        end else begin
            if (cfg_update) begin
                cfg_pend   <= 1'b1;
                pend_scale <= cfg_scale;
            end else if (cfg_hs && (pend_scale == cfg_scale_q)) begin
                // only retire the request once the value actually sent is current
                cfg_pend <= 1'b0;
            end
            if ((state == IDLE) && cfg_pend)
                cfg_scale_q <= pend_scale;
        end
    end

    assign cfg_pend_idle = cfg_pend;
`else
    assign cfg_scale_q   = SCALE_SCHEDULE;
    assign cfg_pend_idle = 1'b0;
`endif

    assign start = (state == IDLE) && !cfg_pend_idle && enable && (hop_cnt >= HOP_LVL);

    // Skid occupancy plus the read in flight must stay within two entries.
    assign occ_after_pop = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == STREAM) && (rd_cnt != LEN_CNT) && (occ_after_pop <= 3'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            CONFIG: if (cfg_hs) state_nxt = IDLE;
            IDLE: begin
                if (cfg_pend_idle) state_nxt = CONFIG;
                else if (start)    state_nxt = STREAM;
            end
            STREAM: if (pop && s_tlast) state_nxt = DRAIN;
            DRAIN:  if (out_done) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = CONFIG;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= CONFIG;
            cfg_tvalid <= 1'b0;
            hop_cnt    <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cfg_tvalid <= (state_nxt == CONFIG);
            if (start)
                hop_cnt <= sample_ready ? CNT_W'(1) : '0;
            else if (sample_ready && (hop_cnt != LEN_CNT))
                hop_cnt <= hop_cnt + CNT_W'(1);
            if (start && ({1'b0, hop_cnt} >= OVR_LVL))
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ram_rd_addr <= '0;
            rd_cnt      <= '0;
            beat_cnt    <= '0;
            inflight    <= 1'b0;
            skid[0]     <= '0;
            skid[1]     <= '0;
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            inflight <= issue;
            if (start) begin
                ram_rd_addr <= wr_addr;
                rd_cnt      <= '0;
                beat_cnt    <= '0;
            end else begin
                if (issue) begin
                    ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
                    rd_cnt      <= rd_cnt + CNT_W'(1);
                end
                if (pop)
                    beat_cnt <= beat_cnt + ADDR_W'(1);
            end
            if (inflight) begin
                skid[skid_wr_ptr] <= ram_rd_data;
                skid_wr_ptr       <= ~skid_wr_ptr;
            end
            if (pop)
                skid_rd_ptr <= ~skid_rd_ptr;
            skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: config handshake, a table of frames
// (wrap, backpressure, long drain, overrun, chained start), overrun clear,
// reset in the middle of a stream and the hop-count threshold after reset.

module tb_fft_frame_sequencer;

    logic        clk;
    logic        reset_b;
    logic        enable;
    logic        sample_ready;
    logic [5:0]  wr_addr;
    logic [5:0]  ram_rd_addr;
    logic [9:0]  ram_rd_data;
    logic        cfg_tvalid;
    logic [7:0]  cfg_tdata;
    logic        cfg_tready;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid, m_tready, m_tlast;
    logic        frame_busy, frame_done, overrun, overrun_clr;

    fft_frame_sequencer dut (
        .clk(clk), .reset_b(reset_b), .enable(enable), .sample_ready(sample_ready),
        .wr_addr(wr_addr), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .cfg_tvalid(cfg_tvalid), .cfg_tdata(cfg_tdata), .cfg_tready(cfg_tready),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    typedef struct {
        logic [5:0] wr;
        bit         stall;
        int         samples;
        int         delay;
        bit         exp_ovr;
        bit         chain;
    } vec_t;

    vec_t       vecs [6];
    logic [9:0] ram_mem [64];
    int         n_tests = 0;
    int         n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_rd_data <= ram_mem[ram_rd_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cfg_tvalid"}, 32'(cfg_tvalid), 0);
        chk({tag, "_s_tvalid"},   32'(s_tvalid),   0);
        chk({tag, "_s_tlast"},    32'(s_tlast),    0);
        chk({tag, "_s_tdata"},    s_tdata,         0);
        chk({tag, "_ram_rd_addr"}, 32'(ram_rd_addr), 0);
        chk({tag, "_frame_busy"}, 32'(frame_busy), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_overrun"},    32'(overrun),    0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_samples(input int n);
        for (int i = 0; i < n; i++) begin
            sample_ready = 1'b1;
            tick();
            sample_ready = 1'b0;
            tick();
        end
    endtask

    // Entered at the sample point just after reset release.
    task automatic do_config(input int low_cycles, input int n_samp);
        int vcnt = 0;
        int hs   = 0;
        int sv   = 0;
        for (int t = 0; t < 40 && hs == 0; t++) begin
            if (s_tvalid) sv++;
            if (t == 1) chk("cfg_valid_first_clock", 32'(cfg_tvalid), 1);
            if (cfg_tvalid) begin
                vcnt++;
                chk("cfg_tdata", 32'(cfg_tdata), 32'h57);
                cfg_tready = (vcnt > low_cycles);
                if (cfg_tready) hs = 1;
            end else begin
                cfg_tready = 1'b0;
            end
            sample_ready = (t >= 1 && t <= n_samp);
            tick();
        end
        sample_ready = 1'b0;
        cfg_tready   = 1'b0;
        chk("cfg_handshake", 32'(hs), 1);
        chk("cfg_valid_cycles", 32'(vcnt), 32'(low_cycles + 1));
        chk("cfg_valid_after_hs", 32'(cfg_tvalid), 0);
        chk("s_tvalid_during_cfg", 32'(sv), 0);
    endtask

    task automatic run_frame(input vec_t v);
        int         busy_t = -1, vld_t = -1, last_t = -1, m_t = -1, done_t = -1;
        int         done_cnt = 0, beats = 0, sent = 0;
        bit         fin = 0;
        logic       stalled = 1'b0, held_last = 1'b0, rdy;
        logic [31:0] held_data = '0;
        logic [5:0] a;
        wr_addr = v.wr;
        enable  = 1'b1;
        for (int t = 0; t < 1500 && !fin; t++) begin
            if (frame_busy && busy_t < 0) begin
                busy_t = t;
                enable = v.chain;
                chk("overrun_at_start", 32'(overrun), 32'(v.exp_ovr));
            end
            if (s_tvalid && vld_t < 0) vld_t = t;
            if (stalled) begin
                chk("stall_valid", 32'(s_tvalid), 1);
                chk("stall_data", s_tdata, held_data);
                chk("stall_last", 32'(s_tlast), 32'(held_last));
            end
            rdy       = v.stall ? (t % 2 == 1) : 1'b1;
            s_tready  = rdy;
            stalled   = s_tvalid && !rdy;
            held_data = s_tdata;
            held_last = s_tlast;
            if (s_tvalid && rdy) begin
                a = v.wr + 6'(beats);
                chk("beat_data", s_tdata, {22'b0, ram_mem[a]});
                chk("beat_last", 32'(s_tlast), 32'(beats == 63));
                beats++;
                if (beats == 64) last_t = t;
            end
            if (last_t >= 0 && t == last_t + 1) chk("valid_after_last", 32'(s_tvalid), 0);
            sample_ready = (busy_t >= 0 && sent < v.samples && ((t - busy_t) % 5 == 1));
            if (sample_ready) sent++;
            m_tvalid = (last_t >= 0 && t == last_t + v.delay);
            m_tready = m_tvalid;
            m_tlast  = m_tvalid;
            if (m_tvalid) begin
                m_t = t;
                chk("busy_in_drain", 32'(frame_busy), 1);
            end
            if (frame_done) begin
                done_cnt++;
                if (done_t < 0) begin
                    done_t = t;
                    chk("busy_at_done", 32'(frame_busy), 0);
                    chk("done_latency", 32'(t - m_t), 1);
                end
            end
            if (done_t >= 0 && t == done_t + 1) chk("busy_after_done", 32'(frame_busy), 0);
            if (done_t >= 0 && t == done_t + 2) begin
                chk("next_start", 32'(frame_busy), 32'(v.chain));
                fin = 1;
            end
            if (!fin) tick();
        end
        sample_ready = 1'b0;
        m_tvalid = 1'b0; m_tready = 1'b0; m_tlast = 1'b0;
        s_tready = 1'b1;
        chk("frame_finished", 32'(fin), 1);
        chk("frame_beats", 32'(beats), 64);
        chk("first_valid_latency", 32'(vld_t - busy_t), 2);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("cfg_idle_in_frame", 32'(cfg_tvalid), 0);
    endtask

    initial begin
        int   hs;
        logic [5:0] a;

        for (int i = 0; i < 64; i++) ram_mem[i] = 10'(i * 13 + 300);
        //          wr     stall samples delay ovr chain
        vecs[0] = '{6'd60, 1'b0, 4,      3,    1'b0, 1'b0};
        vecs[1] = '{6'd60, 1'b1, 4,      100,  1'b0, 1'b0};
        vecs[2] = '{6'd17, 1'b0, 9,      10,   1'b0, 1'b0};
        vecs[3] = '{6'd0,  1'b1, 4,      2,    1'b1, 1'b0};
        vecs[4] = '{6'd33, 1'b0, 5,      1,    1'b0, 1'b1};
        vecs[5] = '{6'd5,  1'b0, 0,      4,    1'b0, 1'b0};

        reset_b = 1'b0; enable = 1'b0; sample_ready = 1'b0; wr_addr = '0;
        cfg_tready = 1'b0; s_tready = 1'b0; overrun_clr = 1'b0;
        m_tvalid = 1'b0; m_tready = 1'b0; m_tlast = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset_b = 1'b1;

        // 4 samples counted while CONFIG is still waiting for cfg_tready.
        do_config(5, 4);
        repeat (3) tick();
        chk("no_start_enable_low", 32'(frame_busy), 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        chk("overrun_sticky", 32'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("overrun_cleared", 32'(overrun), 0);

        run_frame(vecs[4]);

        // Chained frame is running; take 30 beats then reset asynchronously.
        enable = 1'b0;
        s_tready = 1'b1;
        hs = 0;
        for (int t = 0; t < 200 && hs < 30; t++) begin
            if (s_tvalid) begin
                a = vecs[4].wr + 6'(hs);
                chk("chain_data", s_tdata, {22'b0, ram_mem[a]});
                hs++;
            end
            tick();
        end
        chk("beats_before_reset", 32'(hs), 30);
        reset_b = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (2) tick();
        check_reset_vals("mid_reset_hold");
        reset_b = 1'b1;
        do_config(0, 0);

        // Hop counter restarted from zero: three samples are one short.
        enable = 1'b1;
        repeat (4) tick();
        chk("no_start_hop0", 32'(frame_busy), 0);
        enable = 1'b0;
        pulse_samples(3);
        enable = 1'b1;
        repeat (3) tick();
        chk("no_start_hop3", 32'(frame_busy), 0);
        enable = 1'b0;
        pulse_samples(1);
        run_frame(vecs[5]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
